data_mem_responder: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 38 +++
 rtl/data_mem_responder_word_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the handshaked memory-bus responders: FSM states,
// the request bundle, and the address alignment/range/index helpers.
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // True when the byte address is not word aligned or falls outside the
    // window [base, base + depth*WORD_BYTES). The offset is taken modulo 2^32,
    // so an address below base wraps high and also fails the range test.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) ||
               ((off >> $clog2(WORD_BYTES)) >= 32'(depth));
    endfunction

    // Word index of a byte address relative to the window base.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Word array with byte-enabled synchronous write and asynchronous read.
// Contents are deliberately not reset.
module word_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write only the enabled byte lanes; disabled lanes keep their old value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: accepts one load/store per transaction, waits
// WAIT_CYCLES, accesses the word array, then holds the response until taken.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    hold_q, hold_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    mem_req_t    req_in;
    mem_req_t    acc;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0] ram_rdata;
    logic        ram_we;

    assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};

    // With zero wait the access happens on the accept edge itself, so the
    // live request is used; otherwise the captured copy is used.
    assign acc     = (state_q == IDLE) ? req_in : hold_q;
    assign acc_err = addr_bad(acc.addr, ADDR_BASE, DEPTH_WORDS);
    assign acc_idx = AW'(word_index(acc.addr, ADDR_BASE));

    word_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (acc.be),
        .waddr (acc_idx),
        .wdata (acc.wdata),
        .raddr (acc_idx),
        .rdata (ram_rdata)
    );

    // Next-state, wait counter, capture and access/response computation.
    always_comb begin
        logic do_access;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        do_access   = 1'b0;
        ram_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    hold_d = req_in;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc.write) ? 32'h0 : ram_rdata;
            // A reset on the access edge abandons the transaction entirely.
            ram_we      = acc.write && !acc_err && !rst;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            hold_q      <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=2 at base 0 with
// 256 words, WAIT_CYCLES=0 at base 0x1000 with 16 words) driven by directed
// and random transactions, checked against a word-level memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0][3:0]  req_be;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m0 [int];
    logic [31:0] m1 [int];
    int          w0 [$];
    int          w1 [$];

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_0000)) u_w2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_1000)) u_w0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    function automatic int waitc(int d);          return (d == 0) ? 2 : 0;               endfunction
    function automatic longint depth_of(int d);   return (d == 0) ? 256 : 16;            endfunction
    function automatic longint base_of(int d);    return (d == 0) ? 64'h0 : 64'h1000;    endfunction

    function automatic bit model_err(int d, logic [31:0] a);
        longint la;
        la = longint'(a);
        if (la % 4 != 0) return 1'b1;
        if (la < base_of(d)) return 1'b1;
        return ((la - base_of(d)) / 4) >= depth_of(d);
    endfunction

    function automatic logic [31:0] mget(int d, int i);
        return (d == 0) ? m0[i] : m1[i];
    endfunction

    function automatic bit mhas(int d, int i);
        return (d == 0) ? (m0.exists(i) != 0) : (m1.exists(i) != 0);
    endfunction

    task automatic mput(int d, int i, logic [31:0] v);
        if (d == 0) begin
            if (!m0.exists(i)) w0.push_back(i);
            m0[i] = v;
        end else begin
            if (!m1.exists(i)) w1.push_back(i);
            m1[i] = v;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; entered and left 1 time unit after an edge
    // with the responder idle. hold = cycles of response backpressure.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int hold, input string tag, output logic [31:0] obs_rd);
        bit          exp_err;
        logic [31:0] exp_rd, nw;
        int          idx, lat;
        exp_err = model_err(d, addr);
        idx     = int'((longint'(addr) - base_of(d)) / 4);
        exp_rd  = 32'h0;
        if (!exp_err && !wr) exp_rd = mget(d, idx);

        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be;
        chk({tag, ".req_ready"}, 32'(req_ready[d]), 32'h1);
        tick();
        // Scramble fields after accept: they must have no effect.
        req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_be[d] = 4'($urandom);

        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(waitc(d) + 1));
        chk({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
        chk({tag, ".rdata"}, rsp_rdata[d], exp_rd);
        obs_rd = rsp_rdata[d];

        repeat (hold) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(rsp_valid[d]), 32'h1);
            chk({tag, ".hold_rdata"}, rsp_rdata[d], exp_rd);
            chk({tag, ".hold_ready"}, 32'(req_ready[d]), 32'h0);
        end

        if (wr && !exp_err) begin
            nw = mhas(d, idx) ? mget(d, idx) : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wdata[8*b +: 8];
            mput(d, idx, nw);
        end

        rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0;
        chk({tag, ".done_valid"}, 32'(rsp_valid[d]), 32'h0);
        chk({tag, ".done_rdata"}, rsp_rdata[d], 32'h0);
        chk({tag, ".done_err"}, 32'(rsp_err[d]), 32'h0);
        chk({tag, ".done_ready"}, 32'(req_ready[d]), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, a;
        int          idx, r;
        logic [3:0]  be;

        rst = 2'b11; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = '0;

        // Reset state
        tick(); tick();
        rst = 2'b00;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d.req_ready", d), 32'(req_ready[d]), 32'h1);
            chk($sformatf("reset%0d.rsp_valid", d), 32'(rsp_valid[d]), 32'h0);
            chk($sformatf("reset%0d.rsp_rdata", d), rsp_rdata[d], 32'h0);
            chk($sformatf("reset%0d.rsp_err", d), 32'(rsp_err[d]), 32'h0);
        end

        // Store then load, wait 2
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10", rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, "ld10", rd);
        chk("ld10.const", rd, 32'hDEADBEEF);

        // Partial write
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "st20a", rd);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "st20b", rd);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20", rd);
        chk("ld20.const", rd, 32'h11BB33DD);
        // All-zero byte enables: legal no-op write
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, "st20z", rd);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20z", rd);
        chk("ld20z.const", rd, 32'h11BB33DD);

        // Errors: misaligned load, store one past the end
        txn(0, 1'b1, 32'h3FC, 32'h5A5A1234, 4'hF, 0, "st_last", rd);
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, "ld_misal", rd);
        txn(0, 1'b1, 32'h400, 32'h01020304, 4'hF, 0, "st_oor", rd);
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, "ld_last", rd);
        chk("ld_last.const", rd, 32'h5A5A1234);
        // Below-base address on the offset instance wraps and errors
        txn(1, 1'b1, 32'h0000_0FFC, 32'h77777777, 4'hF, 0, "st_below", rd);

        // Backpressure and zero wait
        txn(1, 1'b1, 32'h1004, 32'hA1B2C3D4, 4'hF, 0, "st1004", rd);
        txn(1, 1'b1, 32'h1008, 32'h0BADF00D, 4'hF, 0, "st1008", rd);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h1004;
        tick();
        req_addr[1] = 32'h1008;    // pending request while the response is held
        chk("bp.valid_1edge", 32'(rsp_valid[1]), 32'h1);
        chk("bp.rdata", rsp_rdata[1], 32'hA1B2C3D4);
        repeat (5) begin
            tick();
            chk("bp.hold_valid", 32'(rsp_valid[1]), 32'h1);
            chk("bp.hold_rdata", rsp_rdata[1], 32'hA1B2C3D4);
            chk("bp.hold_err", 32'(rsp_err[1]), 32'h0);
            chk("bp.req_ready", 32'(req_ready[1]), 32'h0);
        end
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        chk("bp.taken_valid", 32'(rsp_valid[1]), 32'h0);
        chk("bp.taken_ready", 32'(req_ready[1]), 32'h1);
        tick();
        req_valid[1] = 1'b0;
        chk("bp.pending_valid", 32'(rsp_valid[1]), 32'h1);
        chk("bp.pending_rdata", rsp_rdata[1], 32'h0BADF00D);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        chk("bp.pending_done", 32'(rsp_valid[1]), 32'h0);

        // Reset mid-WAIT abandons the store
        txn(0, 1'b1, 32'h40, 32'h0, 4'hF, 0, "st40_zero", rd);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h40;
        req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
        tick();
        req_valid[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        tick(); tick();
        rst[0] = 1'b0;
        chk("rstwait.req_ready", 32'(req_ready[0]), 32'h1);
        chk("rstwait.rsp_valid", 32'(rsp_valid[0]), 32'h0);
        repeat (4) begin
            tick();
            chk("rstwait.no_rsp", 32'(rsp_valid[0]), 32'h0);
        end
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, "ld40", rd);
        chk("ld40.const", rd, 32'h0);

        // Random traffic against the model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 30; n++) begin
                r = $urandom_range(0, 9);
                if (r < 8 && r >= 5 && ((d == 0) ? w0.size() : w1.size()) > 0) begin
                    idx = (d == 0) ? w0[$urandom_range(0, w0.size() - 1)]
                                   : w1[$urandom_range(0, w1.size() - 1)];
                    a = 32'(base_of(d) + 4 * idx);
                    txn(d, 1'b0, a, 32'h0, 4'h0, $urandom_range(0, 2), $sformatf("rnd%0d_ld", d), rd);
                end else if (r < 8) begin
                    idx = $urandom_range(0, int'(depth_of(d)) - 1);
                    a   = 32'(base_of(d) + 4 * idx);
                    be  = mhas(d, idx) ? 4'($urandom) : 4'hF;
                    txn(d, 1'b1, a, $urandom, be, $urandom_range(0, 2), $sformatf("rnd%0d_st", d), rd);
                end else begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'(base_of(d) + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                        1:       a = 32'(base_of(d) + 4 * depth_of(d) + 4 * $urandom_range(0, 7));
                        default: a = 32'(base_of(d)) - 32'(4 * $urandom_range(1, 8));
                    endcase
                    txn(d, 1'($urandom), a, $urandom, 4'hF, 0, $sformatf("rnd%0d_err", d), rd);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
